// File: rtl/snake_flow_ctrl_if.sv
// Handshake bundle between the Snake game-flow controller and its datapath/overlay.
// The controller takes the slave view; buttons, collision logic and the datapath take the master view.
interface snake_flow_ctrl_if #(
  parameter int LENGTH_W = 8
);
  logic                Ack;
  logic                Pause;
  logic                Collision;
  logic [LENGTH_W-1:0] Length;
  logic                q_I;
  logic                q_Count;
  logic                q_Run;
  logic                q_Pause;
  logic                q_Respawn;
  logic                q_Lose;
  logic                q_Win;
  logic                Move_Tick;
  logic                Respawn_Req;
  logic [2:0]          Lives;
  logic [3:0]          Count;

  modport master (
    output Ack, Pause, Collision, Length,
    input  q_I, q_Count, q_Run, q_Pause, q_Respawn, q_Lose, q_Win,
    input  Move_Tick, Respawn_Req, Lives, Count
  );

  modport slave (
    input  Ack, Pause, Collision, Length,
    output q_I, q_Count, q_Run, q_Pause, q_Respawn, q_Lose, q_Win,
    output Move_Tick, Respawn_Req, Lives, Count
  );
endinterface

// File: rtl/snake_flow_ctrl.sv
// Snake game-flow controller: countdown, run, pause, lives with respawn, lose/win,
// plus the game-tick divider that paces snake moves.
module snake_flow_ctrl #(
  parameter int LENGTH_W      = 8,
  parameter int WIN_LENGTH    = 225,
  parameter int LIVES         = 3,
  parameter int TICK_DIV      = 25_000_000,
  parameter int COUNTDOWN     = 3,
  parameter int RESPAWN_TICKS = 2
) (
  input logic              Clk,
  input logic              Reset,
  snake_flow_ctrl_if.slave bus
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int RSP_W = $clog2(RESPAWN_TICKS + 1);

  localparam logic [DIV_W-1:0]    TICK_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [RSP_W-1:0]    RSP_LAST   = RSP_W'(RESPAWN_TICKS - 1);
  localparam logic [2:0]          LIVES_INIT = 3'(LIVES);
  localparam logic [3:0]          CD_INIT    = 4'(COUNTDOWN);
  localparam logic [LENGTH_W-1:0] WIN_LEN    = LENGTH_W'(WIN_LENGTH);

  typedef enum logic [6:0] {
    S_I       = 7'b000_0001,
    S_COUNT   = 7'b000_0010,
    S_RUN     = 7'b000_0100,
    S_PAUSE   = 7'b000_1000,
    S_RESPAWN = 7'b001_0000,
    S_LOSE    = 7'b010_0000,
    S_WIN     = 7'b100_0000
  } state_t;

  // Kept as a plain vector so that any non one-hot value can be recognised and recovered.
  logic [6:0]       state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_wrap;
  logic [RSP_W-1:0] rsp_reg;
  logic [2:0]       lives_reg;
  logic [3:0]       count_reg;
  logic             respawn_req_reg;
  logic             tick;

  assign tick     = (div_reg == TICK_LAST);
  assign div_wrap = tick ? '0 : div_reg + DIV_W'(1);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg       <= S_I;
      div_reg         <= '0;
      rsp_reg         <= '0;
      lives_reg       <= LIVES_INIT;
      count_reg       <= CD_INIT;
      respawn_req_reg <= 1'b0;
    end else begin
      respawn_req_reg <= 1'b0;
      case (state_reg)
        S_I: begin
          lives_reg <= LIVES_INIT;
          count_reg <= CD_INIT;
          div_reg   <= '0;
          state_reg <= (COUNTDOWN == 0) ? S_RUN : S_COUNT;
        end
        S_COUNT: begin
          div_reg <= div_wrap;
          if (tick) begin
            if (count_reg <= 4'd1) begin
              count_reg <= '0;
              state_reg <= S_RUN;
            end else begin
              count_reg <= count_reg - 4'd1;
            end
          end
        end
        S_RUN: begin
          div_reg <= div_wrap;
          if (bus.Collision) begin
            div_reg <= '0;
            if (lives_reg <= 3'd1) begin
              lives_reg <= '0;
              state_reg <= S_LOSE;
            end else begin
              lives_reg       <= lives_reg - 3'd1;
              rsp_reg         <= '0;
              respawn_req_reg <= 1'b1;
              state_reg       <= S_RESPAWN;
            end
          end else if (bus.Length >= WIN_LEN) begin
            div_reg   <= '0;
            state_reg <= S_WIN;
          end else if (bus.Pause) begin
            // Divider freezes at its current phase so the move cadence resumes seamlessly.
            div_reg   <= div_reg;
            state_reg <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (bus.Pause) begin
            state_reg <= S_RUN;
          end
        end
        S_RESPAWN: begin
          div_reg <= div_wrap;
          if (tick) begin
            if (rsp_reg == RSP_LAST) begin
              rsp_reg   <= '0;
              count_reg <= CD_INIT;
              state_reg <= (COUNTDOWN == 0) ? S_RUN : S_COUNT;
            end else begin
              rsp_reg <= rsp_reg + RSP_W'(1);
            end
          end
        end
        S_LOSE, S_WIN: begin
          div_reg <= '0;
          if (bus.Ack) begin
            state_reg <= S_I;
          end
        end
        default: begin
          div_reg   <= '0;
          rsp_reg   <= '0;
          state_reg <= S_I;
        end
      endcase
    end
  end

  assign {bus.q_Win, bus.q_Lose, bus.q_Respawn, bus.q_Pause,
          bus.q_Run, bus.q_Count, bus.q_I} = state_reg;

  assign bus.Move_Tick   = bus.q_Run & tick;
  assign bus.Respawn_Req = respawn_req_reg;
  assign bus.Lives       = lives_reg;
  assign bus.Count       = count_reg;

endmodule

// File: tb/tb_snake_flow_ctrl.sv
// Bench for snake_flow_ctrl: directed scenarios plus random play, all checked against
// a cycle-count model of the game flow.
`timescale 1ns/1ps
module tb_snake_flow_ctrl;

  localparam int TD = 4;
  localparam int CD = 3;
  localparam int NL = 2;
  localparam int RT = 2;
  localparam int WL = 10;

  localparam int P_I = 0, P_COUNT = 1, P_RUN = 2, P_PAUSE = 3;
  localparam int P_RESPAWN = 4, P_LOSE = 5, P_WIN = 6, P_BAD = 7;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  snake_flow_ctrl_if #(.LENGTH_W(8)) bus ();

  snake_flow_ctrl #(
    .LENGTH_W(8), .WIN_LENGTH(WL), .LIVES(NL),
    .TICK_DIV(TD), .COUNTDOWN(CD), .RESPAWN_TICKS(RT)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc_no = 0;
  // Model: game phase, lives, count and cycles the divider has run within the phase.
  int   m_phase   = P_I;
  int   m_lives   = NL;
  int   m_count   = CD;
  int   m_elapsed = 0;
  logic m_req     = 1'b0;

  function automatic logic [15:0] dut_vec();
    return {bus.q_I, bus.q_Count, bus.q_Run, bus.q_Pause, bus.q_Respawn, bus.q_Lose,
            bus.q_Win, bus.Move_Tick, bus.Respawn_Req, bus.Lives, bus.Count};
  endfunction

  function automatic logic [15:0] model_vec();
    logic mv;
    mv = (m_phase == P_RUN) && ((m_elapsed % TD) == TD - 1);
    return {m_phase == P_I, m_phase == P_COUNT, m_phase == P_RUN, m_phase == P_PAUSE,
            m_phase == P_RESPAWN, m_phase == P_LOSE, m_phase == P_WIN,
            mv, m_req, 3'(m_lives), 4'(m_count)};
  endfunction

  function automatic logic [6:0] q_flags();
    return {bus.q_I, bus.q_Count, bus.q_Run, bus.q_Pause, bus.q_Respawn, bus.q_Lose, bus.q_Win};
  endfunction

  task automatic model_step();
    if (!Reset) begin
      m_phase = P_I; m_lives = NL; m_count = CD; m_elapsed = 0; m_req = 1'b0;
      return;
    end
    m_req = 1'b0;
    case (m_phase)
      P_I: begin
        m_lives = NL; m_count = CD; m_elapsed = 0;
        m_phase = (CD == 0) ? P_RUN : P_COUNT;
      end
      P_COUNT: begin
        m_elapsed++;
        m_count = CD - m_elapsed / TD;
        if (m_elapsed == CD * TD) begin
          m_phase = P_RUN; m_elapsed = 0; m_count = 0;
        end
      end
      P_RUN: begin
        if (bus.Collision) begin
          m_elapsed = 0;
          if (m_lives <= 1) begin
            m_lives = 0; m_phase = P_LOSE;
          end else begin
            m_lives--; m_req = 1'b1; m_phase = P_RESPAWN;
          end
        end else if (int'(bus.Length) >= WL) begin
          m_elapsed = 0; m_phase = P_WIN;
        end else if (bus.Pause) begin
          m_phase = P_PAUSE;
        end else begin
          m_elapsed++;
        end
      end
      P_PAUSE: if (bus.Pause) m_phase = P_RUN;
      P_RESPAWN: begin
        m_elapsed++;
        if (m_elapsed == RT * TD) begin
          m_elapsed = 0; m_count = CD;
          m_phase = (CD == 0) ? P_RUN : P_COUNT;
        end
      end
      P_LOSE, P_WIN: if (bus.Ack) m_phase = P_I;
      default: begin
        m_phase = P_I; m_elapsed = 0;
      end
    endcase
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_step();
    cyc_no++;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if ({bus.q_I, bus.Lives, bus.Count, bus.Move_Tick, bus.Respawn_Req} !== {1'b1, 3'd2, 4'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state cyc=%0d got q_I=%b Lives=%0d Count=%0d Move=%b Req=%b, want 1 2 3 0 0",
               cyc_no, bus.q_I, bus.Lives, bus.Count, bus.Move_Tick, bus.Respawn_Req);
    end
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_vec cyc=%0d got=%h want=%h", cyc_no, dut_vec(), model_vec());
    end
  endtask

  task automatic test_countdown();
    logic exp_move;
    Reset = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      cyc();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL countdown_vec c=%0d got=%h want=%h", c, dut_vec(), model_vec());
      end
      if (c == 1 || c == 5 || c == 9) begin
        n_cmp++;
        if (bus.q_Count !== 1'b1 || int'(bus.Count) != 3 - (c - 1) / 4) begin
          n_fail++;
          $display("FAIL countdown_value c=%0d got q_Count=%b Count=%0d want 1 %0d",
                   c, bus.q_Count, bus.Count, 3 - (c - 1) / 4);
        end
      end
      if (c == 13) begin
        n_cmp++;
        if (bus.q_Run !== 1'b1 || bus.Count !== 4'd0) begin
          n_fail++;
          $display("FAIL countdown_run c=%0d got q_Run=%b Count=%0d want 1 0", c, bus.q_Run, bus.Count);
        end
      end
      if (c >= 13) begin
        exp_move = (c == 16 || c == 20 || c == 24);
        n_cmp++;
        if (bus.Move_Tick !== exp_move) begin
          n_fail++;
          $display("FAIL move_tick c=%0d got=%b want=%b", c, bus.Move_Tick, exp_move);
        end
      end
    end
  endtask

  task automatic test_respawn();
    int n_resp;
    bus.Collision = 1'b1;
    cyc();
    bus.Collision = 1'b0;
    n_cmp++;
    if ({bus.q_Respawn, bus.Respawn_Req, bus.Lives} !== {1'b1, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL respawn_enter got q_Respawn=%b Req=%b Lives=%0d want 1 1 1",
               bus.q_Respawn, bus.Respawn_Req, bus.Lives);
    end
    n_resp = 1;
    for (int i = 0; i < 20 && bus.q_Respawn === 1'b1; i++) begin
      cyc();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL respawn_vec cyc=%0d got=%h want=%h", cyc_no, dut_vec(), model_vec());
      end
      if (bus.q_Respawn === 1'b1) n_resp++;
    end
    n_cmp++;
    if (n_resp != RT * TD || bus.q_Count !== 1'b1 || bus.Count !== 4'd3) begin
      n_fail++;
      $display("FAIL respawn_len got cycles=%0d q_Count=%b Count=%0d want 8 1 3",
               n_resp, bus.q_Count, bus.Count);
    end
    for (int i = 0; i < 40 && m_phase != P_RUN; i++) begin
      cyc();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL respawn_count_vec cyc=%0d got=%h want=%h", cyc_no, dut_vec(), model_vec());
      end
    end
    bus.Collision = 1'b1;
    cyc();
    bus.Collision = 1'b0;
    n_cmp++;
    if ({bus.q_Lose, bus.Lives, bus.Respawn_Req} !== {1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL lose_enter got q_Lose=%b Lives=%0d Req=%b want 1 0 0", bus.q_Lose, bus.Lives, bus.Respawn_Req);
    end
    repeat (3) cyc();
    bus.Ack = 1'b1;
    cyc();
    bus.Ack = 1'b0;
    n_cmp++;
    if (bus.q_I !== 1'b1) begin
      n_fail++;
      $display("FAIL lose_ack got q_I=%b want 1", bus.q_I);
    end
    cyc();
    n_cmp++;
    if (bus.Lives !== 3'd2 || bus.q_Count !== 1'b1) begin
      n_fail++;
      $display("FAIL lives_reload got Lives=%0d q_Count=%b want 2 1", bus.Lives, bus.q_Count);
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 60 && !(m_phase == P_RUN && (m_elapsed % TD) == 2); i++) begin
      cyc();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL pause_pre_vec cyc=%0d got=%h want=%h", cyc_no, dut_vec(), model_vec());
      end
    end
    bus.Pause = 1'b1;
    cyc();
    bus.Pause = 1'b0;
    n_cmp++;
    if (bus.q_Pause !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_enter got q_Pause=%b want 1", bus.q_Pause);
    end
    for (int i = 0; i < 50; i++) begin
      bus.Collision = 1'($urandom_range(0, 1));
      bus.Ack       = 1'($urandom_range(0, 1));
      cyc();
      n_cmp++;
      if (bus.Move_Tick !== 1'b0 || bus.q_Pause !== 1'b1 || dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL pause_hold i=%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    bus.Collision = 1'b0;
    bus.Ack       = 1'b0;
    bus.Pause     = 1'b1;
    cyc();
    bus.Pause = 1'b0;
    n_cmp++;
    if (bus.q_Run !== 1'b1 || bus.Move_Tick !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_resume got q_Run=%b Move=%b want 1 0", bus.q_Run, bus.Move_Tick);
    end
    cyc();
    n_cmp++;
    if (bus.Move_Tick !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_first_move got=%b want 1", bus.Move_Tick);
    end
  endtask

  task automatic test_win();
    bus.Length    = 8'd10;
    bus.Collision = 1'b1;
    cyc();
    bus.Length    = 8'd0;
    bus.Collision = 1'b0;
    n_cmp++;
    if (bus.q_Respawn !== 1'b1 || bus.Lives !== 3'd1) begin
      n_fail++;
      $display("FAIL win_vs_collision got q_Respawn=%b Lives=%0d want 1 1", bus.q_Respawn, bus.Lives);
    end
    for (int i = 0; i < 40 && m_phase != P_RUN; i++) begin
      cyc();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL win_pre_vec cyc=%0d got=%h want=%h", cyc_no, dut_vec(), model_vec());
      end
    end
    bus.Length = 8'd10;
    cyc();
    bus.Length = 8'd0;
    n_cmp++;
    if (bus.q_Win !== 1'b1) begin
      n_fail++;
      $display("FAIL win_enter got q_Win=%b want 1", bus.q_Win);
    end
    for (int i = 0; i < 20; i++) begin
      bus.Pause     = 1'($urandom_range(0, 1));
      bus.Collision = 1'($urandom_range(0, 1));
      cyc();
      n_cmp++;
      if (bus.q_Win !== 1'b1 || dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL win_hold i=%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    bus.Pause     = 1'b0;
    bus.Collision = 1'b0;
    bus.Ack       = 1'b1;
    cyc();
    bus.Ack = 1'b0;
    n_cmp++;
    if (bus.q_I !== 1'b1) begin
      n_fail++;
      $display("FAIL win_ack got q_I=%b want 1", bus.q_I);
    end
  endtask

  task automatic test_reset_mid();
    repeat (6) cyc();
    Reset = 1'b0;
    #2;
    n_cmp++;
    if (dut_vec() !== model_vec() || bus.q_Count !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_edge got=%h want=%h", dut_vec(), model_vec());
    end
    cyc();
    Reset = 1'b1;
    n_cmp++;
    if ({bus.q_I, bus.Lives, bus.Count, bus.Move_Tick} !== {1'b1, 3'd2, 4'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_countdown got q_I=%b Lives=%0d Count=%0d Move=%b want 1 2 3 0",
               bus.q_I, bus.Lives, bus.Count, bus.Move_Tick);
    end
    for (int i = 0; i < 40 && m_phase != P_RUN; i++) cyc();
    bus.Pause = 1'b1;
    cyc();
    bus.Pause = 1'b0;
    repeat (3) cyc();
    n_cmp++;
    if (bus.q_Pause !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pause_setup got q_Pause=%b want 1", bus.q_Pause);
    end
    Reset = 1'b0;
    cyc();
    Reset = 1'b1;
    n_cmp++;
    if ({bus.q_I, bus.Lives, bus.Count, bus.Move_Tick} !== {1'b1, 3'd2, 4'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_pause got q_I=%b Lives=%0d Count=%0d Move=%b want 1 2 3 0",
               bus.q_I, bus.Lives, bus.Count, bus.Move_Tick);
    end
  endtask

  task automatic test_illegal();
    repeat (3) cyc();
    force dut.state_reg = 7'b000_0110;
    #1;
    release dut.state_reg;
    m_phase = P_BAD;
    cyc();
    n_cmp++;
    if (q_flags() !== 7'b100_0000 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL illegal_recover got=%h want=%h", dut_vec(), model_vec());
    end
    for (int i = 0; i < 30; i++) begin
      cyc();
      n_cmp++;
      if (!$onehot(q_flags()) || dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL illegal_after i=%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      Reset         = ($urandom_range(0, 299) != 0);
      bus.Collision = ($urandom_range(0, 39) == 0);
      bus.Pause     = ($urandom_range(0, 19) == 0);
      bus.Ack       = ($urandom_range(0, 9) == 0);
      bus.Length    = ($urandom_range(0, 99) == 0) ? 8'($urandom_range(10, 255)) : 8'($urandom_range(0, 9));
      cyc();
      n_cmp++;
      if (!$onehot(q_flags()) || dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random i=%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    Reset = 1'b1;
  endtask

  initial begin
    bus.Ack       = 1'b0;
    bus.Pause     = 1'b0;
    bus.Collision = 1'b0;
    bus.Length    = 8'd0;
    test_reset();
    test_countdown();
    test_respawn();
    test_pause();
    test_win();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc_no);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snake_flow_ctrl.md
# snake_flow_ctrl

Parametrised game-flow controller for the Snake game: successor to the four-state Init/Run/Lose/Win controller. Adds a start countdown, multiple lives with a respawn phase, pause/resume, and an internal game-tick divider. It drives the one-hot state outputs and the per-move enable consumed by the snake datapath and VGA overlay. Sits between the debounced button/collision logic and the snake body/score datapath.

## Interface

Parameters:
- LENGTH_W, 8: width of Length.
- WIN_LENGTH, 225: snake length that wins the game.
- LIVES, 3: lives at game start, 1..7.
- TICK_DIV, 25_000_000: Clk cycles per game tick, ≥2.
- COUNTDOWN, 3: ticks of countdown before play, 0..15.
- RESPAWN_TICKS, 2: ticks spent in respawn, ≥1.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  **synchronous, active-low** reset.
- Ack  in  1  one-cycle pulse; leaves LOSE/WIN.
- Pause  in  1  one-cycle pulse; toggles RUN↔PAUSE.
- Collision  in  1  snake hit wall/self; level-sampled every cycle.
- Length  in  LENGTH_W  current snake length.
- q_I, q_Count, q_Run, q_Pause, q_Respawn, q_Lose, q_Win  out  1 each  one-hot state flags.
- Move_Tick  out  1  one-cycle move enable, only in RUN.
- Respawn_Req  out  1  one-cycle pulse: datapath resets snake body, keeps score.
- Lives  out  3  remaining lives.
- Count  out  4  countdown value for display.

## Operation

- State register one-hot, 7 states; any illegal encoding → I on next edge (never X).
- Divider div, width $clog2(TICK_DIV): counts 0..TICK_DIV-1 and wraps in COUNT, RUN, RESPAWN; frozen in PAUSE; cleared to 0 on every state change except RUN↔PAUSE; held 0 in I, LOSE, WIN. tick = (div == TICK_DIV-1).
- Reset (Reset=0 at edge): state I, Lives=LIVES, Count=COUNTDOWN, div=0, Respawn_Req=0. Move_Tick=0 follows.
- I: Lives←LIVES, Count←COUNTDOWN; next edge → COUNT (→ RUN directly if COUNTDOWN=0).
- COUNT: on tick Count←Count-1; the tick with Count==1 sets Count←0 and → RUN. Collision, Pause ignored.
- RUN, priority per edge: Collision > Length ≥ WIN_LENGTH > Pause.
  - Collision, Lives==1: Lives←0, → LOSE.
  - Collision, Lives>1: Lives←Lives-1, Respawn_Req=1 for that one cycle, → RESPAWN.
  - Length ≥ WIN_LENGTH: → WIN.
  - Pause: → PAUSE.
- PAUSE: Pause → RUN with div resumed from frozen value; Collision, Ack ignored.
- RESPAWN: after RESPAWN_TICKS ticks, Count←COUNTDOWN and → COUNT (→ RUN if COUNTDOWN=0).
- LOSE / WIN: hold; Ack → I. Lives and Count hold their values.
- Lives never underflows; Count never underflows.

## Timing

- Move_Tick = q_Run & tick, decoded only from registers; glitch-free, 1 cycle wide, period TICK_DIV while in RUN.
- Same-edge Collision and tick in RUN: Move_Tick still asserts that cycle; state changes at that edge.
- Respawn_Req registered: high in the first cycle of RESPAWN only.
- Countdown length: COUNT entered at cycle t → RUN at t + COUNTDOWN·TICK_DIV.
- Reset has priority over all inputs, including mid-countdown and mid-pause.
- Pause and Ack have no effect outside the states listed.

## Test plan

Params for all tests: TICK_DIV=4, COUNTDOWN=3, LIVES=2, RESPAWN_TICKS=2, WIN_LENGTH=10.
- Reset release at cycle 0 → q_I at cycle 0, q_Count at 1 with Count=3; Count=2 at 5, 1 at 9; q_Run at 13 with Count=0; Move_Tick pulses at cycles 16, 20, 24.
- Collision in RUN with Lives=2 → Lives=1, Respawn_Req for exactly one cycle, q_Respawn for 8 cycles, then q_Count with Count=3; second Collision → q_Lose, Lives=0; Ack → q_I, then Lives=2.
- In RUN: Pause at div=2 → q_Pause, no Move_Tick for 50 cycles; Collision during pause ignored; Pause → q_Run; first Move_Tick 1 cycle later (div resumes 2→3).
- Length=10 and Collision on the same edge → Collision wins, Lives decrements; then Length=10 alone in RUN → q_Win; Ack held low 20 cycles → stays q_Win.
- Reset=0 mid-countdown and in PAUSE → next edge q_I, Lives=2, Count=3, Move_Tick=0; Reset=0 without clock edge changes nothing.
- Force an illegal state (two bits set) → q_I next edge; all q_* one-hot thereafter.
